// File: rtl/datagen_pkg.sv
// Shared constants, pattern codes and FSM encoding for the stream data generator.
package datagen_pkg;

    localparam logic [1:0] MODE_TAGGED = 2'd0;
    localparam logic [1:0] MODE_INCR   = 2'd1;
    localparam logic [1:0] MODE_LFSR   = 2'd2;

    localparam logic [7:0] TAG_TABLE [16] = '{
        8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
        8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF
    };

    // Galois taps for x^32+x^22+x^2+x+1 in right-shifting form
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;

    localparam int DEFAULT_PKT_LEN = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic logic [31:0] rotl32(input logic [31:0] v, input logic [4:0] n);
        logic [63:0] dbl;
        dbl = {v, v} << n;
        return dbl[63:32];
    endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR; load has priority over advance.
module lfsr32
    import datagen_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] state
);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LFSR_SEED;
        end else if (load) begin
            state <= seed;
        end else if (advance) begin
            state <= {1'b0, state[31:1]} ^ ({32{state[0]}} & LFSR_TAPS);
        end
    end

endmodule

// File: rtl/stream_data_generator.sv
// AXI-Stream test-traffic source: batches of fixed-length packets with selectable payload,
// inter-packet gap, continuous mode and stop/restart serviced only at packet boundaries.
module stream_data_generator
    import datagen_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int LEN_WIDTH  = 8,
    parameter int GAP_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [63:0]               packet_count,
    input  logic [LEN_WIDTH-1:0]      packet_length,
    input  logic [GAP_WIDTH-1:0]      gap_cycles,
    input  logic [1:0]                mode,
    input  logic                      start,
    input  logic                      stop,
    output logic                      busy,
    output logic                      done,
    output logic [63:0]               packets_sent,
    output logic [DATA_WIDTH-1:0]     AXIS_TX_TDATA,
    output logic [DATA_WIDTH/8-1:0]   AXIS_TX_TKEEP,
    output logic                      AXIS_TX_TVALID,
    output logic                      AXIS_TX_TLAST,
    input  logic                      AXIS_TX_TREADY
);

    localparam int W = DATA_WIDTH / 32;

    state_t               state;
    logic [63:0]          count_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [GAP_WIDTH-1:0] gap_q;
    logic [GAP_WIDTH-1:0] gap_left;
    logic [1:0]           mode_q;
    logic [LEN_WIDTH-1:0] cycle_index;
    logic [15:0]          counter;
    logic [15:0]          packet_num;
    logic [63:0]          sent_q;
    logic                 start_pend;
    logic                 stop_pend;
    logic                 tvalid_q;
    logic                 done_q;
    logic [31:0]          lfsr_state;

    logic accept;
    logic last_beat;
    logic launch;
    logic batch_end;

    assign accept    = tvalid_q & AXIS_TX_TREADY;
    assign last_beat = (cycle_index == len_q);
    // A queued relaunch fires even if stop pulses in the idle cycle; a fresh start loses to stop.
    assign launch    = (state == ST_IDLE) & (start_pend | (start & ~stop));
    assign batch_end = (count_q != 64'd0) && ((sent_q + 64'd1) == count_q);

    lfsr32 u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (launch),
        .seed    (LFSR_SEED),
        .advance (accept),
        .state   (lfsr_state)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            tvalid_q    <= 1'b0;
            done_q      <= 1'b0;
            start_pend  <= 1'b0;
            stop_pend   <= 1'b0;
            sent_q      <= '0;
            packet_num  <= '0;
            counter     <= '0;
            cycle_index <= LEN_WIDTH'(1);
            count_q     <= '0;
            len_q       <= LEN_WIDTH'(DEFAULT_PKT_LEN);
            gap_q       <= '0;
            gap_left    <= '0;
            mode_q      <= MODE_TAGGED;
        end else begin
            done_q <= 1'b0;
            if (state != ST_IDLE) begin
                if (start && !stop) start_pend <= 1'b1;
                if (stop)           stop_pend  <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        count_q     <= packet_count;
                        len_q       <= (packet_length == '0) ? LEN_WIDTH'(DEFAULT_PKT_LEN) : packet_length;
                        gap_q       <= gap_cycles;
                        mode_q      <= mode;
                        packet_num  <= '0;
                        counter     <= '0;
                        sent_q      <= '0;
                        cycle_index <= LEN_WIDTH'(1);
                        start_pend  <= 1'b0;
                        stop_pend   <= 1'b0;
                        state       <= ST_SEND;
                        tvalid_q    <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (accept) begin
                        counter     <= counter + 16'd1;
                        cycle_index <= last_beat ? LEN_WIDTH'(1) : cycle_index + LEN_WIDTH'(1);
                        if (last_beat) begin
                            sent_q     <= sent_q + 64'd1;
                            packet_num <= packet_num + 16'd1;
                            if (stop_pend || stop) begin
                                state      <= ST_IDLE;
                                tvalid_q   <= 1'b0;
                                done_q     <= 1'b1;
                                start_pend <= 1'b0;
                                stop_pend  <= 1'b0;
                            end else if (start_pend || start) begin
                                state      <= ST_IDLE;
                                tvalid_q   <= 1'b0;
                                start_pend <= 1'b1;
                            end else if (batch_end) begin
                                state    <= ST_IDLE;
                                tvalid_q <= 1'b0;
                                done_q   <= 1'b1;
                            end else if (gap_q != '0) begin
                                state    <= ST_GAP;
                                tvalid_q <= 1'b0;
                                gap_left <= gap_q;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    gap_left <= gap_left - GAP_WIDTH'(1);
                    if (gap_left <= GAP_WIDTH'(1)) begin
                        state    <= ST_SEND;
                        tvalid_q <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    tvalid_q <= 1'b0;
                end
            endcase
        end
    end

    // Payload is built from registered state only, so it holds while the beat is stalled.
    always_comb begin
        logic [31:0] word;
        word          = '0;
        AXIS_TX_TDATA = '0;
        AXIS_TX_TDATA[31:0] = 32'hFFFF_FFFF;
        for (int i = 1; i < W; i++) begin
            case (mode_q)
                MODE_INCR: word = {counter, packet_num[7:0], 8'(i)};
                MODE_LFSR: word = rotl32(lfsr_state, 5'(i));
                default:   word = {TAG_TABLE[4'(i % 16)], counter[7:0], packet_num};
            endcase
            AXIS_TX_TDATA[32*i +: 32] = word;
        end
    end

    assign AXIS_TX_TKEEP  = '1;
    assign AXIS_TX_TVALID = tvalid_q;
    assign AXIS_TX_TLAST  = tvalid_q & last_beat;
    assign busy           = (state != ST_IDLE);
    assign done           = done_q;
    assign packets_sent   = sent_q;

endmodule

// File: tb/tb_stream_data_generator.sv
// Directed bench for stream_data_generator at 512-bit and 64-bit data widths.
module tb_stream_data_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [63:0]  a_count;
    logic [7:0]   a_len, a_gap;
    logic [1:0]   a_mode;
    logic         a_start, a_stop, a_busy, a_done, a_tvalid, a_tlast, a_tready;
    logic [63:0]  a_sent;
    logic [511:0] a_tdata;
    logic [63:0]  a_tkeep;

    logic [63:0]  b_count;
    logic [7:0]   b_len, b_gap;
    logic [1:0]   b_mode;
    logic         b_start, b_stop, b_busy, b_done, b_tvalid, b_tlast, b_tready;
    logic [63:0]  b_sent;
    logic [63:0]  b_tdata;
    logic [7:0]   b_tkeep;

    int vec  = 0;
    int errs = 0;

    stream_data_generator #(.DATA_WIDTH(512), .LEN_WIDTH(8), .GAP_WIDTH(8)) dut_a (
        .clk(clk), .reset(reset), .packet_count(a_count), .packet_length(a_len),
        .gap_cycles(a_gap), .mode(a_mode), .start(a_start), .stop(a_stop),
        .busy(a_busy), .done(a_done), .packets_sent(a_sent),
        .AXIS_TX_TDATA(a_tdata), .AXIS_TX_TKEEP(a_tkeep), .AXIS_TX_TVALID(a_tvalid),
        .AXIS_TX_TLAST(a_tlast), .AXIS_TX_TREADY(a_tready)
    );

    stream_data_generator #(.DATA_WIDTH(64), .LEN_WIDTH(8), .GAP_WIDTH(8)) dut_b (
        .clk(clk), .reset(reset), .packet_count(b_count), .packet_length(b_len),
        .gap_cycles(b_gap), .mode(b_mode), .start(b_start), .stop(b_stop),
        .busy(b_busy), .done(b_done), .packets_sent(b_sent),
        .AXIS_TX_TDATA(b_tdata), .AXIS_TX_TKEEP(b_tkeep), .AXIS_TX_TVALID(b_tvalid),
        .AXIS_TX_TLAST(b_tlast), .AXIS_TX_TREADY(b_tready)
    );

    function automatic logic [31:0] a_word(input int i);
        return a_tdata[32*i +: 32];
    endfunction

    task automatic a_kick();
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_count = 0; a_len = 0; a_gap = 0; a_mode = 0; a_start = 0; a_stop = 0; a_tready = 1;
        b_count = 0; b_len = 0; b_gap = 0; b_mode = 0; b_start = 0; b_stop = 0; b_tready = 1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vec++; if (a_tvalid !== 1'b0) begin errs++; $display("FAIL reset_tvalid got %b want 0", a_tvalid); end
        vec++; if (a_busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", a_busy); end
        vec++; if (a_done !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", a_done); end
        vec++; if (a_sent !== 64'd0) begin errs++; $display("FAIL reset_sent got %0d want 0", a_sent); end
        vec++; if (b_tvalid !== 1'b0) begin errs++; $display("FAIL reset_b_tvalid got %b want 0", b_tvalid); end
        a_stop = 1'b1;
        @(negedge clk);
        a_stop = 1'b0;
        @(negedge clk);
        vec++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin errs++; $display("FAIL idle_stop got busy=%b done=%b want 0/0", a_busy, a_done); end
        a_start = 1'b1; a_stop = 1'b1;
        @(negedge clk);
        a_start = 1'b0; a_stop = 1'b0;
        vec++; if (a_tvalid !== 1'b0 || a_busy !== 1'b0) begin errs++; $display("FAIL start_stop_same got tvalid=%b busy=%b want 0/0", a_tvalid, a_busy); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int beats = 0, first = -1, last = -100, dones = 0;
        a_count = 3; a_len = 2; a_gap = 0; a_mode = 0; a_tready = 1;
        a_kick();
        for (int c = 0; c < 20; c++) begin
            if (a_tvalid) begin
                beats++;
                if (beats == 1) begin
                    first = c;
                    vec++; if (a_word(0) !== 32'hFFFF_FFFF) begin errs++; $display("FAIL b2b_word0 got %h want ffffffff", a_word(0)); end
                    vec++; if (a_tkeep !== {64{1'b1}}) begin errs++; $display("FAIL b2b_tkeep got %h want all ones", a_tkeep); end
                    vec++; if (a_word(2) !== 32'h2200_0000) begin errs++; $display("FAIL b2b_w2_beat1 got %h want 22000000", a_word(2)); end
                end
                vec++; if (a_tlast !== (beats % 2 == 0)) begin errs++; $display("FAIL b2b_tlast beat %0d got %b", beats, a_tlast); end
                vec++; if (a_word(1) !== {8'h11, 8'(beats - 1), 16'((beats - 1) / 2)}) begin errs++; $display("FAIL b2b_w1 beat %0d got %h", beats, a_word(1)); end
                if (beats == 3) begin
                    vec++; if (a_word(1) !== 32'h1102_0001) begin errs++; $display("FAIL b2b_w1_beat3 got %h want 11020001", a_word(1)); end
                end
                if (beats == 6) begin
                    last = c;
                    vec++; if (a_word(15) !== 32'hFF05_0002) begin errs++; $display("FAIL b2b_w15_beat6 got %h want ff050002", a_word(15)); end
                end
            end
            if (a_done) dones++;
            if (c == last + 1) begin
                vec++; if (a_done !== 1'b1 || a_busy !== 1'b0) begin errs++; $display("FAIL b2b_done_timing got done=%b busy=%b want 1/0", a_done, a_busy); end
                vec++; if (a_sent !== 64'd3) begin errs++; $display("FAIL b2b_sent got %0d want 3", a_sent); end
            end
            @(negedge clk);
        end
        vec++; if (beats != 6 || first != 0 || last != 5) begin errs++; $display("FAIL b2b_shape got beats=%0d first=%0d last=%0d want 6/0/5", beats, first, last); end
        vec++; if (dones != 1) begin errs++; $display("FAIL b2b_done_count got %0d want 1", dones); end
    endtask

    task automatic test_gap_stall();
        int beats = 0, idle = 0, dones = 0;
        logic         prev_stalled = 1'b0;
        logic [512:0] prev = '0;
        a_count = 2; a_len = 4; a_gap = 5; a_mode = 1; a_tready = 0;
        a_kick();
        for (int c = 0; c < 60; c++) begin
            a_tready = (c % 2 == 0);
            if (a_tvalid) begin
                if (prev_stalled) begin
                    vec++; if ({a_tlast, a_tdata} !== prev) begin errs++; $display("FAIL stall_stable cycle %0d beat %0d data changed", c, beats + 1); end
                end
                if (a_tready) begin
                    beats++;
                    vec++; if (a_word(1) !== {16'(beats - 1), 8'((beats - 1) / 4), 8'h01}) begin errs++; $display("FAIL incr_w1 beat %0d got %h", beats, a_word(1)); end
                    if (beats == 5) begin
                        vec++; if (a_word(1) !== 32'h0004_0101) begin errs++; $display("FAIL incr_w1_beat5 got %h want 00040101", a_word(1)); end
                    end
                    if (beats == 8) begin
                        vec++; if (a_word(2) !== 32'h0007_0102) begin errs++; $display("FAIL incr_w2_beat8 got %h want 00070102", a_word(2)); end
                    end
                end
                prev_stalled = !a_tready;
                prev = {a_tlast, a_tdata};
            end else begin
                if (beats == 4) idle++;
                prev_stalled = 1'b0;
            end
            if (a_done) begin
                dones++;
                vec++; if (a_sent !== 64'd2) begin errs++; $display("FAIL gap_sent got %0d want 2", a_sent); end
            end
            @(negedge clk);
        end
        a_tready = 1'b1;
        vec++; if (idle != 5) begin errs++; $display("FAIL gap_idle got %0d want 5", idle); end
        vec++; if (beats != 8 || dones != 1) begin errs++; $display("FAIL gap_beats got beats=%0d dones=%0d want 8/1", beats, dones); end
    endtask

    task automatic test_stop_continuous();
        int beats = 0, dones = 0;
        logic stopped = 1'b0;
        a_count = 0; a_len = 3; a_gap = 1; a_mode = 3; a_tready = 1;
        a_kick();
        for (int c = 0; c < 120; c++) begin
            a_stop = 1'b0;
            if (a_tvalid) begin
                beats++;
                if (a_sent == 64'd6 && ((beats - 1) % 3) == 1 && !stopped) begin
                    a_stop = 1'b1;
                    stopped = 1'b1;
                end
                if (beats == 21) begin
                    vec++; if (a_word(1) !== 32'h1114_0006 || a_tlast !== 1'b1) begin errs++; $display("FAIL stop_last_beat got w1=%h tlast=%b want 11140006/1", a_word(1), a_tlast); end
                end
            end
            if (a_done) begin
                dones++;
                vec++; if (a_sent !== 64'd7) begin errs++; $display("FAIL stop_sent got %0d want 7", a_sent); end
            end
            @(negedge clk);
        end
        vec++; if (beats != 21 || dones != 1 || a_busy !== 1'b0) begin errs++; $display("FAIL stop_shape got beats=%0d dones=%0d busy=%b want 21/1/0", beats, dones, a_busy); end
    endtask

    task automatic test_restart();
        int phase = 0, idle = 0, new_beats = 0, dones = 0;
        a_count = 10; a_len = 2; a_gap = 0; a_mode = 0; a_tready = 1;
        a_kick();
        for (int c = 0; c < 60; c++) begin
            a_start = 1'b0;
            if (a_tvalid) begin
                case (phase)
                    0: if (a_sent == 64'd2 && !a_tlast) begin a_start = 1'b1; phase = 1; end
                    1: if (a_tlast) phase = 2;
                    2: begin
                        vec++; if (idle != 1) begin errs++; $display("FAIL restart_idle got %0d want 1", idle); end
                        vec++; if (a_word(1) !== 32'h1100_0000) begin errs++; $display("FAIL restart_w1 got %h want 11000000", a_word(1)); end
                        vec++; if (a_sent !== 64'd0) begin errs++; $display("FAIL restart_sent_clear got %0d want 0", a_sent); end
                        phase = 3;
                        new_beats = 1;
                    end
                    default: new_beats++;
                endcase
            end else if (phase == 2) begin
                idle++;
                vec++; if (a_sent !== 64'd3) begin errs++; $display("FAIL restart_sent_idle got %0d want 3", a_sent); end
            end
            if (a_done) begin
                dones++;
                vec++; if (phase != 3 || a_sent !== 64'd10) begin errs++; $display("FAIL restart_done got phase=%0d sent=%0d want 3/10", phase, a_sent); end
            end
            @(negedge clk);
        end
        vec++; if (new_beats != 20 || dones != 1) begin errs++; $display("FAIL restart_shape got beats=%0d dones=%0d want 20/1", new_beats, dones); end
    endtask

    task automatic test_lfsr64();
        int beats = 0, dones = 0;
        logic [31:0] lfsr = 32'hACE1_0001;
        b_count = 1; b_len = 0; b_gap = 0; b_mode = 2; b_tready = 1;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (b_tvalid) begin
                beats++;
                vec++; if (b_tdata[63:32] !== {lfsr[30:0], lfsr[31]} || b_tdata[31:0] !== 32'hFFFF_FFFF) begin errs++; $display("FAIL lfsr_beat %0d got %h want %h_ffffffff", beats, b_tdata, {lfsr[30:0], lfsr[31]}); end
                if (beats == 1) begin
                    vec++; if (b_tdata[63:32] !== 32'h59C2_0003) begin errs++; $display("FAIL lfsr_beat1 got %h want 59c20003", b_tdata[63:32]); end
                end
                if (beats == 2) begin
                    vec++; if (b_tdata[63:32] !== 32'hACA1_0007) begin errs++; $display("FAIL lfsr_beat2 got %h want aca10007", b_tdata[63:32]); end
                end
                vec++; if (b_tlast !== (beats == 4)) begin errs++; $display("FAIL lfsr_tlast beat %0d got %b", beats, b_tlast); end
                lfsr = (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
            end
            if (b_done) dones++;
            @(negedge clk);
        end
        vec++; if (beats != 4 || dones != 1 || b_sent !== 64'd1) begin errs++; $display("FAIL lfsr_shape got beats=%0d dones=%0d sent=%0d want 4/1/1", beats, dones, b_sent); end
    endtask

    task automatic test_reset_mid();
        logic reached = 1'b0;
        int beats = 0, dones = 0;
        a_count = 5; a_len = 4; a_gap = 0; a_mode = 0; a_tready = 1;
        a_kick();
        for (int c = 0; c < 40 && !reached; c++) begin
            if (a_sent == 64'd1 && a_tvalid) reached = 1'b1;
            else @(negedge clk);
        end
        vec++; if (!reached) begin errs++; $display("FAIL rst_mid_reach got sent=%0d want 1 within budget", a_sent); end
        a_tready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vec++; if (a_tvalid !== 1'b0 || a_tlast !== 1'b0) begin errs++; $display("FAIL rst_mid_tvalid got tvalid=%b tlast=%b want 0/0", a_tvalid, a_tlast); end
        vec++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_sent !== 64'd0) begin errs++; $display("FAIL rst_mid_state got busy=%b done=%b sent=%0d want 0/0/0", a_busy, a_done, a_sent); end
        a_tready = 1'b1;
        repeat (2) @(negedge clk);
        vec++; if (a_tvalid !== 1'b0) begin errs++; $display("FAIL rst_mid_quiet got tvalid=%b want 0", a_tvalid); end
        a_count = 1; a_len = 2;
        a_kick();
        for (int c = 0; c < 10; c++) begin
            if (a_tvalid) begin
                beats++;
                if (beats == 1) begin
                    vec++; if (a_word(1) !== 32'h1100_0000 || a_tlast !== 1'b0) begin errs++; $display("FAIL rst_relaunch_beat1 got w1=%h tlast=%b want 11000000/0", a_word(1), a_tlast); end
                end
            end
            if (a_done) dones++;
            @(negedge clk);
        end
        vec++; if (beats != 2 || dones != 1 || a_sent !== 64'd1) begin errs++; $display("FAIL rst_relaunch_shape got beats=%0d dones=%0d sent=%0d want 2/1/1", beats, dones, a_sent); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gap_stall();
        test_stop_continuous();
        test_restart();
        test_lfsr64();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
